// File: rtl/calc_sequencer.sv
// Sequenced arithmetic unit: single-cycle add/sub, W-step shift-add multiply,
// registered result with a one-cycle done pulse and an error flag for the reserved op.
module calc_sequencer #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*W-1:0] result,
    output logic [1:0]     state_dbg
);

    // Handshake: start is a request sampled only while busy=0; everything else
    // about it is ignored. done pulses for one cycle while result/err are valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state, state_nx;
    logic [1:0]     op_q;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nx;
    logic [CW-1:0]  cnt;
    logic [W:0]     sum;
    logic [W:0]     diff;

    // mcand/mplier double as the latched operands for add and sub
    assign sum    = {1'b0, mcand[W-1:0]} + {1'b0, mplier};
    assign diff   = {1'b0, mcand[W-1:0]} - {1'b0, mplier};
    assign acc_nx = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (op == OP_MUL) ? MUL : EXEC;
            EXEC: state_nx = DONE;
            MUL:  if (cnt == LAST) state_nx = DONE;
            DONE: if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        mcand  <= {{W{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        err    <= 1'b0;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_ADD:  result <= {{(W-1){1'b0}}, sum};
                        OP_SUB:  result <= {{W{diff[W]}}, diff[W-1:0]};
                        default: begin
                            result <= '0;
                            err    <= 1'b1;
                        end
                    endcase
                end
                MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) result <= acc_nx;
                end
                DONE: begin
                    // first DONE cycle raises the pulse, second drops it on exit
                    done <= !done;
                end
                default: done <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter: W, default 4, operand width in bits; result width is 2*W.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  operation: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-006 SHALL have port: a  input  W  operand A, unsigned.
REQ-007 SHALL have port: b  input  W  operand B, unsigned.
REQ-008 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when result is valid.
REQ-010 SHALL have port: err  output  1  high with done when op was reserved.
REQ-011 SHALL have port: result  output  2*W  registered result.

Function
REQ-012 SHALL implement the FSM states IDLE, EXEC, MUL, and DONE.
REQ-013 In IDLE, when start=1 at edge N, the block SHALL latch a, b and op, clear the multiply accumulator and iteration counter, and enter EXEC (op 00/01/11) or MUL (op 10).
REQ-014 In IDLE, when start=0, the block SHALL stay in IDLE with result held.
REQ-015 EXEC add SHALL compute result = zero-extended {carry, a+b} at edge N+1, with bits [2W-1:W+1] = 0 and bit W = carry.
REQ-016 EXEC sub SHALL compute result = a - b as a 2W-bit two's-complement value, sign-extended, at edge N+1.
REQ-017 EXEC reserved op SHALL set result = 0 and err = 1 at edge N+1.
REQ-018 After EXEC, the block SHALL go to DONE; latency from start edge to done high is 2 edges for add, sub and reserved.
REQ-019 MUL SHALL perform shift-add over exactly W iterations: on each edge, if the current multiplier LSB is 1, add the shifted multiplicand into the 2W-bit accumulator; then shift, and increment the counter.
REQ-020 When counter = W-1 in MUL, the block SHALL write the accumulator to result on that edge and go to DONE; mul latency is W+1 edges.
REQ-021 Every multiply add SHALL be unsigned and SHALL NOT overflow the 2W-bit accumulator, since (2^W-1)^2 < 2^(2W).
REQ-022 DONE SHALL hold done=1 for exactly one cycle, then return to IDLE on the next edge.
REQ-023 err SHALL be cleared on the next accepted start.
REQ-024 A start asserted while busy=1 SHALL be ignored: no latch, no queue, and no effect on the in-flight operation.
REQ-025 A start held high through DONE SHALL be accepted only in the following IDLE cycle, giving a minimum of one IDLE cycle between operations.
REQ-026 Changes on a, b or op after the start edge SHALL NOT affect the in-flight result.
REQ-027 result SHALL remain stable from its write until the next accepted operation writes it.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force state IDLE, busy=0, done=0, err=0, result=0, accumulator=0 and counter=0, regardless of clk.
REQ-029 A reset during EXEC, MUL or DONE SHALL abort the operation with no done pulse.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-031 Bench SHALL cover: W=4, op=00, a=15, b=15, start at edge 0 -> result=0x1E, done high after edge 2, busy high after edges 0-2.
REQ-032 Bench SHALL cover: op=01, a=3, b=5 -> result=0xFE after edge 2; op=01, a=9, b=4 -> result=0x05.
REQ-033 Bench SHALL cover: op=10, a=15, b=15 -> result=0xE1 with done after edge 5; a=0, b=13 -> result=0x00 with the same latency.
REQ-034 Bench SHALL cover: start=1 during MUL with different operands -> original product unchanged and no second done; start held through DONE -> next operation starts one IDLE cycle later.
REQ-035 Bench SHALL cover: op=11 -> err=1, result=0, done after edge 2; the following valid add clears err.
REQ-036 Bench SHALL cover: rst_n pulsed low mid-MUL between clock edges -> outputs 0 immediately, no done, and a fresh add completes normally afterwards.
